// File: rtl/bbqm_pkg.sv
// ============================================================================
// Module   : bbqm_pkg
// Purpose  : Shared widths, limits and sensor FSM encoding for the queue counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bbqm_pkg;

    localparam int PCOUNT_W = 3;
    localparam int TCOUNT_W = 2;
    localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = 3'd7;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        BLOCKED = 1'b1
    } sensor_state_t;

endpackage

`default_nettype wire

// File: rtl/bbqm_sensor_edge.sv
// ============================================================================
// Module   : bbqm_sensor_edge
// Purpose  : One photocell: 2-flop synchronizer, optional debounce
//            (BBQM_DEBOUNCE_EN), and a rising-edge FSM with a registered strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bbqm_sensor_edge
    import bbqm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_in,
    output logic event_out
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_cfg_check
        $error("DEBOUNCE_CYCLES must be within 1..15");
    end

    logic          r_sync1;
    logic          r_sync2;
    logic          w_level;
    sensor_state_t r_state;
    logic          r_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sensor_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef BBQM_DEBOUNCE_EN
    localparam logic [3:0] c_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       r_level;
    logic [3:0] r_stab;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_stab  <= 4'd0;
        end else if (r_sync2 == r_level) begin
            r_stab  <= 4'd0;
        end else if (r_stab == c_LAST) begin
            r_level <= r_sync2;
            r_stab  <= 4'd0;
        end else begin
            r_stab  <= r_stab + 4'd1;
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_event <= 1'b0;
        end else begin
            r_event <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_level) begin
                        r_state <= BLOCKED;
                        r_event <= 1'b1;
                    end
                end
                BLOCKED: begin
                    if (!w_level) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign event_out = r_event;

endmodule

`default_nettype wire

// File: rtl/bbqm_queue_counter.sv
// ============================================================================
// Module   : bbqm_queue_counter
// Purpose  : Saturating bank-queue occupancy counter with full/empty/overflow
//            flags and a synchronized teller count. Debounce via BBQM_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bbqm_queue_counter
    import bbqm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enter_sensor,
    input  logic                exit_sensor,
    input  logic [TCOUNT_W-1:0] tcount_sw,
    output logic [PCOUNT_W-1:0] pcount,
    output logic [TCOUNT_W-1:0] tcount,
    output logic                full,
    output logic                empty,
    output logic                overflow
);

    logic                w_ent;
    logic                w_ext;
    logic [PCOUNT_W-1:0] w_pcount_nxt;
    logic                w_ovf_set;
    logic [PCOUNT_W-1:0] r_pcount;
    logic                r_full;
    logic                r_empty;
    logic                r_overflow;
    logic [TCOUNT_W-1:0] r_tsync1;
    logic [TCOUNT_W-1:0] r_tcount;

    bbqm_sensor_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor_in (enter_sensor),
        .event_out (w_ent)
    );

    bbqm_sensor_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor_in (exit_sensor),
        .event_out (w_ext)
    );

    // Simultaneous entry and exit cancel out, and never flag overflow.
    always_comb begin
        w_pcount_nxt = r_pcount;
        w_ovf_set    = 1'b0;
        case ({w_ent, w_ext})
            2'b10: begin
                if (r_pcount == PCOUNT_MAX) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_pcount_nxt = r_pcount + 3'd1;
                end
            end
            2'b01: begin
                if (r_pcount != '0) begin
                    w_pcount_nxt = r_pcount - 3'd1;
                end
            end
            default: w_pcount_nxt = r_pcount;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcount   <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_tsync1   <= '0;
            r_tcount   <= '0;
        end else begin
            r_pcount   <= w_pcount_nxt;
            r_full     <= (w_pcount_nxt == PCOUNT_MAX);
            r_empty    <= (w_pcount_nxt == '0);
            r_overflow <= r_overflow | w_ovf_set;
            r_tsync1   <= tcount_sw;
            r_tcount   <= r_tsync1;
        end
    end

    assign pcount   = r_pcount;
    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_overflow;
    assign tcount   = r_tcount;

endmodule

`default_nettype wire
